mem_controller_mc: RTL and testbench
====================================

Name: mem_controller_mc

Overview:
- Synthesizable, multi-channel successor of the single-channel memory controller.
- Pops {ID, flag, address, data} requests from NUM_CH request FIFOs, arbitrates round-robin onto one tagged memory port, and tracks up to MAX_OUT outstanding transactions.
- Routes each tagged memory response back as {ID, data} into the originating channel's response FIFO.
- Sits between the per-module dataports and the memory model / bus bridge.

Parameters:
- NUM_CH, 4, number of request/response channel pairs
- CH_WIDTH, 2, bits to encode a channel index (clog2 NUM_CH)
- DATA_WIDTH, 32, data field width
- ADDR_WIDTH, 31, address field width
- TID_WIDTH, 16, transaction ID width
- MAX_OUT, 8, outstanding-transaction table depth
- TAG_WIDTH, 3, memory tag width (clog2 MAX_OUT)
- REQ_W, TID_WIDTH+1+ADDR_WIDTH+DATA_WIDTH, request word layout {tid, rw, addr, data}, MSB first
- RSP_W, TID_WIDTH+DATA_WIDTH, response word layout {tid, data}

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_empty  in  NUM_CH  request FIFO empty, per channel
- req_rd_en  out  NUM_CH  request FIFO pop, per channel
- req_data  in  NUM_CH*REQ_W  FWFT request head; channel c at [c*REQ_W +: REQ_W]
- rsp_full  in  NUM_CH  response FIFO full
- rsp_wr_en  out  NUM_CH  response FIFO push
- rsp_data  out  RSP_W  response word, shared by all channels
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  1 = read, 0 = write
- mem_req_addr  out  ADDR_WIDTH  request address
- mem_req_data  out  DATA_WIDTH  request write data
- mem_req_tag  out  TAG_WIDTH  allocated tag
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_ready  out  1  controller accepts response
- mem_rsp_tag  in  TAG_WIDTH  response tag
- mem_rsp_data  in  DATA_WIDTH  read data, or write ack data
- outstanding  out  TAG_WIDTH+1  number of allocated tags
- err_tag  out  1  sticky: response received with an unallocated tag

Behaviour:
- Reset (reset_n low, asynchronous):
  - All table valid bits cleared; round-robin pointer = 0.
  - mem_req_valid = 0; outstanding = 0; err_tag = 0; req_rd_en = 0; rsp_wr_en = 0; mem_rsp_ready = 0.
  - Mid-operation reset discards in-flight transactions; no responses are emitted for them.
- Request FIFOs are first-word-fall-through: req_data is valid whenever req_empty = 0; a cycle with req_rd_en high pops the head.
- Issue slot is free when mem_req_valid = 0, or when mem_req_valid = 1 and mem_req_ready = 1 this cycle.
- Grant condition: slot free AND outstanding < MAX_OUT AND at least one channel has req_empty = 0.
- On grant:
  - Round-robin picks the first non-empty channel at or after the pointer.
  - req_rd_en[c] is asserted combinationally for exactly one cycle.
  - The lowest-index free tag is allocated.
  - Table entry {valid=1, ch=c, tid} is written.
  - Next edge: mem_req_* loads {rw, addr, data, tag} and mem_req_valid = 1.
  - Pointer moves to c+1, wrapping at NUM_CH.
- Latency is one cycle from pop to mem_req_valid. Back-to-back issue at 1 per cycle is possible while mem_req_ready stays high.
- mem_req_* fields are held stable while mem_req_valid = 1 and mem_req_ready = 0.
- Response path is fully combinational, with no added latency:
  - Look up entry t = mem_rsp_tag; ch = entry.ch.
  - mem_rsp_ready = !entry.valid OR !rsp_full[ch].
  - On handshake with entry.valid: rsp_wr_en[ch] = 1; rsp_data = {entry.tid, mem_rsp_data}; entry cleared on the edge.
  - Handshake with !entry.valid: response dropped, no rsp_wr_en, err_tag set (sticky until reset).
- Same-cycle events:
  - Allocation and free in the same cycle: outstanding = outstanding + 1 - 1, i.e. unchanged.
  - A tag freed this cycle is not eligible for allocation until the next cycle.
  - At outstanding = MAX_OUT, no grant occurs. A free in that same cycle enables a grant next cycle.
- A response for a tag issued in cycle N is legal from cycle N+1 (after mem_req handshake).

Decomposition:
- Package mem_ctrl_pkg holds:
  - width constants (DATA_WIDTH, ADDR_WIDTH, TID_WIDTH, REQ_W, RSP_W);
  - request field offsets (RW_BIT, ADDR_LSB, TID_LSB);
  - the tag-table entry type {valid, ch, tid}.
- One sub-module: rr_arbiter (NUM_CH requests, pointer, one-hot grant, grant index, advance input).
- Free-tag priority encoding stays inline.

Test Plan:
- Single read: ch0 head {tid=0x0001, rw=1, addr=0x10, data=7}, mem_req_ready=1 -> cycle+1 mem_req {rw=1, addr=0x10, tag=0}; mem_rsp tag=0 data=0xAB -> rsp_wr_en[0]=1, rsp_data={0x0001, 0x000000AB}, outstanding back to 0.
- Fairness: all 4 channels non-empty continuously, ready=1 -> grants in order ch0, ch1, ch2, ch3, ch0, with tags 0..4.
- Saturation: 8 issues with no responses -> outstanding=8, no req_rd_en despite non-empty FIFOs. Respond tag 3 -> next grant reuses tag 3 on the following cycle.
- Backpressure: mem_req_ready=0 for 5 cycles -> mem_req fields stable, no further pops. Response to ch2 while rsp_full[2]=1 -> mem_rsp_ready=0 until full drops, then one push.
- Out-of-order: tags 0 (ch1) and 1 (ch3) outstanding, respond tag 1 then tag 0 -> pushes to ch3 then ch1 with the correct tids.
- Error/reset: response with unallocated tag 5 -> accepted, no push, err_tag=1. reset_n pulsed low with 3 tags outstanding -> all outputs 0, outstanding=0, err_tag=0.

Source files
------------

// File: rtl/mem_controller_mc_pkg.sv
// Shared widths, request field offsets and tag-table entry type for the multi-channel memory controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    localparam int NUM_CH     = 4;
    localparam int CH_WIDTH   = 2;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 31;
    localparam int TID_WIDTH  = 16;
    localparam int MAX_OUT    = 8;
    localparam int TAG_WIDTH  = 3;

    // Request word {tid, rw, addr, data}, MSB first
    localparam int REQ_W = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;
    // Response word {tid, data}
    localparam int RSP_W = TID_WIDTH + DATA_WIDTH;

    localparam int ADDR_LSB = DATA_WIDTH;
    localparam int RW_BIT   = ADDR_LSB + ADDR_WIDTH;
    localparam int TID_LSB  = RW_BIT + 1;

    // One outstanding transaction: owning channel and the tid to return
    typedef struct packed {
        logic                 valid;
        logic [CH_WIDTH-1:0]  ch;
        logic [TID_WIDTH-1:0] tid;
    } tag_entry_t;

endpackage

// File: rtl/mem_controller_mc_if.sv
// Bundle of request/response FIFO ports, tagged memory port and status for mem_controller_mc.
// Latency: n/a (wiring only).
// Backpressure: carries FIFO empty/full and memory ready/valid handshakes.
interface mem_controller_mc_if;
    import mem_ctrl_pkg::*;

    logic [NUM_CH-1:0]        req_empty;
    logic [NUM_CH-1:0]        req_rd_en;
    logic [NUM_CH*REQ_W-1:0]  req_data;
    logic [NUM_CH-1:0]        rsp_full;
    logic [NUM_CH-1:0]        rsp_wr_en;
    logic [RSP_W-1:0]         rsp_data;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_rw;
    logic [ADDR_WIDTH-1:0]    mem_req_addr;
    logic [DATA_WIDTH-1:0]    mem_req_data;
    logic [TAG_WIDTH-1:0]     mem_req_tag;
    logic                     mem_rsp_valid;
    logic                     mem_rsp_ready;
    logic [TAG_WIDTH-1:0]     mem_rsp_tag;
    logic [DATA_WIDTH-1:0]    mem_rsp_data;
    logic [TAG_WIDTH:0]       outstanding;
    logic                     err_tag;

    // Controller side
    modport master (
        input  req_empty, req_data, rsp_full, mem_req_ready,
               mem_rsp_valid, mem_rsp_tag, mem_rsp_data,
        output req_rd_en, rsp_wr_en, rsp_data, mem_req_valid, mem_req_rw,
               mem_req_addr, mem_req_data, mem_req_tag, mem_rsp_ready,
               outstanding, err_tag
    );

    // FIFO / memory side
    modport slave (
        output req_empty, req_data, rsp_full, mem_req_ready,
               mem_rsp_valid, mem_rsp_tag, mem_rsp_data,
        input  req_rd_en, rsp_wr_en, rsp_data, mem_req_valid, mem_req_rw,
               mem_req_addr, mem_req_data, mem_req_tag, mem_rsp_ready,
               outstanding, err_tag
    );

endinterface

// File: rtl/mem_controller_mc_rr_arbiter.sv
// Round-robin arbiter: first requesting channel at or after the pointer wins.
// Latency: combinational grant; pointer moves to winner+1 on the edge when advance_i is high.
// Backpressure: pointer holds while advance_i is low, so an unserved winner keeps priority.
module rr_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_CH-1:0]   req_i,
    input  logic                advance_i,
    output logic                gnt_vld_o,
    output logic [NUM_CH-1:0]   gnt_oh_o,
    output logic [CH_WIDTH-1:0] gnt_idx_o
);

    logic [CH_WIDTH-1:0] ptr_q;
    logic [CH_WIDTH-1:0] ptr_d;
    logic [CH_WIDTH:0]   cand;

    // Scan channels starting at the pointer, wrapping at NUM_CH
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        gnt_oh_o  = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, ptr_q} + (CH_WIDTH+1)'(i);
            if (cand >= (CH_WIDTH+1)'(NUM_CH)) begin
                cand = cand - (CH_WIDTH+1)'(NUM_CH);
            end
            if (!gnt_vld_o && req_i[cand[CH_WIDTH-1:0]]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = cand[CH_WIDTH-1:0];
            end
        end
        if (gnt_vld_o) begin
            gnt_oh_o[gnt_idx_o] = 1'b1;
        end
    end

    // Next pointer is one past the winner
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && gnt_vld_o) begin
            ptr_d = (gnt_idx_o == CH_WIDTH'(NUM_CH - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_controller_mc.sv
// Arbitrates NUM_CH request FIFOs onto one tagged memory port and routes tagged responses back per channel.
// Latency: 1 cycle pop-to-mem_req_valid; response path is combinational (0 cycles).
// Backpressure: issue stalls on mem_req_ready=0 or full tag table; responses stall on the target rsp_full.
module mem_controller_mc
    import mem_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    mem_controller_mc_if.master bus
);

    tag_entry_t          tbl_q [MAX_OUT];
    tag_entry_t          tbl_d [MAX_OUT];

    logic                free_vld;
    logic [TAG_WIDTH-1:0] free_tag;
    logic [TAG_WIDTH:0]  occ;

    logic                arb_vld;
    logic [NUM_CH-1:0]   arb_oh;
    logic [CH_WIDTH-1:0] arb_idx;
    logic                slot_free;
    logic                grant;
    logic [REQ_W-1:0]    head;

    logic                    req_vld_q;
    logic                    req_rw_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic [DATA_WIDTH-1:0]   req_data_q;
    logic [TAG_WIDTH-1:0]    req_tag_q;

    tag_entry_t          rsp_ent;
    logic                rsp_rdy;
    logic                rsp_hs;
    logic                rsp_push;
    logic [NUM_CH-1:0]   rsp_wr;
    logic                err_q;
    logic                err_d;

    rr_arbiter u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (~bus.req_empty),
        .advance_i (grant),
        .gnt_vld_o (arb_vld),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    // Lowest free tag and occupancy, both from registered state so a tag freed this cycle is not reused yet
    always_comb begin
        free_vld = 1'b0;
        free_tag = '0;
        occ      = '0;
        for (int t = MAX_OUT - 1; t >= 0; t--) begin
            if (!tbl_q[t].valid) begin
                free_vld = 1'b1;
                free_tag = TAG_WIDTH'(t);
            end
            occ = occ + (TAG_WIDTH+1)'(tbl_q[t].valid);
        end
    end

    // Select the winning channel's FIFO head
    always_comb begin
        head = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (arb_idx == CH_WIDTH'(c)) begin
                head = bus.req_data[c*REQ_W +: REQ_W];
            end
        end
    end

    assign slot_free = !req_vld_q || bus.mem_req_ready;
    assign grant     = reset_n && slot_free && free_vld && arb_vld;

    assign bus.req_rd_en     = grant ? arb_oh : '0;
    assign bus.mem_req_valid = req_vld_q;
    assign bus.mem_req_rw    = req_rw_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_req_data  = req_data_q;
    assign bus.mem_req_tag   = req_tag_q;
    assign bus.outstanding   = occ;
    assign bus.err_tag       = err_q;

    // Issue register: load on grant, drop after handshake, hold under backpressure
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_vld_q  <= 1'b0;
            req_rw_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_tag_q  <= '0;
        end else if (grant) begin
            req_vld_q  <= 1'b1;
            req_rw_q   <= head[RW_BIT];
            req_addr_q <= head[ADDR_LSB +: ADDR_WIDTH];
            req_data_q <= head[DATA_WIDTH-1:0];
            req_tag_q  <= free_tag;
        end else if (bus.mem_req_ready) begin
            req_vld_q  <= 1'b0;
        end
    end

    // Response lookup; unknown tags are always accepted and dropped
    always_comb begin
        rsp_ent  = tbl_q[bus.mem_rsp_tag];
        rsp_rdy  = reset_n && (!rsp_ent.valid || !bus.rsp_full[rsp_ent.ch]);
        rsp_hs   = bus.mem_rsp_valid && rsp_rdy;
        rsp_push = rsp_hs && rsp_ent.valid;
        rsp_wr   = '0;
        if (rsp_push) begin
            rsp_wr[rsp_ent.ch] = 1'b1;
        end
        err_d = err_q || (rsp_hs && !rsp_ent.valid);
    end

    assign bus.mem_rsp_ready = rsp_rdy;
    assign bus.rsp_wr_en     = rsp_wr;
    assign bus.rsp_data      = {rsp_ent.tid, bus.mem_rsp_data};

    // Table next state: free on response push, allocate on grant (never the same tag)
    always_comb begin
        tbl_d = tbl_q;
        if (rsp_push) begin
            tbl_d[bus.mem_rsp_tag].valid = 1'b0;
        end
        if (grant) begin
            tbl_d[free_tag].valid = 1'b1;
            tbl_d[free_tag].ch    = arb_idx;
            tbl_d[free_tag].tid   = head[TID_LSB +: TID_WIDTH];
        end
    end

    // Tag table and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < MAX_OUT; t++) begin
                tbl_q[t] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int t = 0; t < MAX_OUT; t++) begin
                tbl_q[t] <= tbl_d[t];
            end
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_controller_mc.sv
// Directed self-checking bench for mem_controller_mc.
// Latency: checks 1-cycle issue and combinational response routing.
// Backpressure: exercises mem_req_ready stall, rsp_full stall and tag-table saturation.
module tb_mem_controller_mc;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_controller_mc_if bus();

    mem_controller_mc dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_head(input int ch, input logic [15:0] tid, input logic rw,
                            input logic [30:0] addr, input logic [31:0] data);
        bus.req_data[ch*REQ_W +: REQ_W] = {tid, rw, addr, data};
    endtask

    task automatic idle_inputs();
        bus.req_empty     = '1;
        bus.rsp_full      = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_tag   = '0;
        bus.mem_rsp_data  = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic respond(input logic [2:0] tag, input logic [31:0] data);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag   = tag;
        bus.mem_rsp_data  = data;
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.req_data = '0;
        idle_inputs();
        #2;
        // Reset state, with a non-empty FIFO and a response presented
        bus.req_empty = 4'hE;
        respond(3'd0, 32'h1);
        settle();
        check("rst_req_vld",   64'(bus.mem_req_valid), 64'd0);
        check("rst_outst",     64'(bus.outstanding),   64'd0);
        check("rst_err",       64'(bus.err_tag),       64'd0);
        check("rst_rd_en",     64'(bus.req_rd_en),     64'd0);
        check("rst_wr_en",     64'(bus.rsp_wr_en),     64'd0);
        check("rst_rsp_rdy",   64'(bus.mem_rsp_ready), 64'd0);
        do_reset();

        // Single read on ch0
        set_head(0, 16'h0001, 1'b1, 31'h10, 32'd7);
        bus.req_empty     = 4'hE;
        bus.mem_req_ready = 1'b1;
        settle();
        check("t1_pop", 64'(bus.req_rd_en), 64'b0001);
        tick();
        bus.req_empty = 4'hF;
        check("t1_vld",   64'(bus.mem_req_valid), 64'd1);
        check("t1_rw",    64'(bus.mem_req_rw),    64'd1);
        check("t1_addr",  64'(bus.mem_req_addr),  64'h10);
        check("t1_data",  64'(bus.mem_req_data),  64'd7);
        check("t1_tag",   64'(bus.mem_req_tag),   64'd0);
        check("t1_outst", 64'(bus.outstanding),   64'd1);
        tick();
        respond(3'd0, 32'hAB);
        settle();
        check("t1_rsp_rdy", 64'(bus.mem_rsp_ready), 64'd1);
        check("t1_wr_en",   64'(bus.rsp_wr_en),     64'b0001);
        check("t1_rsp_dat", 64'(bus.rsp_data),      64'h0001_0000_00AB);
        tick();
        bus.mem_rsp_valid = 1'b0;
        check("t1_outst_end", 64'(bus.outstanding),   64'd0);
        check("t1_vld_end",   64'(bus.mem_req_valid), 64'd0);

        // Fairness, then saturation of the tag table
        do_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            set_head(c, 16'h0100 + 16'(c), 1'b0, 31'h20 + 31'(c), 32'(c));
        end
        bus.req_empty     = 4'h0;
        bus.mem_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            check($sformatf("fair_pop%0d", k), 64'(bus.req_rd_en), 64'(1 << (k % 4)));
            tick();
            check($sformatf("fair_tag%0d", k),  64'(bus.mem_req_tag),  64'(k));
            check($sformatf("fair_addr%0d", k), 64'(bus.mem_req_addr), 64'h20 + 64'(k % 4));
        end
        check("sat_outst", 64'(bus.outstanding), 64'd8);
        settle();
        check("sat_nopop0", 64'(bus.req_rd_en), 64'd0);
        tick();
        check("sat_nopop1", 64'(bus.req_rd_en),     64'd0);
        check("sat_vld",    64'(bus.mem_req_valid), 64'd0);
        respond(3'd3, 32'h33);
        settle();
        check("sat_wr_en",   64'(bus.rsp_wr_en), 64'b1000);
        check("sat_rsp_dat", 64'(bus.rsp_data),  64'h0103_0000_0033);
        check("sat_nopop2",  64'(bus.req_rd_en), 64'd0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        settle();
        check("sat_outst7", 64'(bus.outstanding), 64'd7);
        check("sat_regrant", 64'(bus.req_rd_en),  64'b0001);
        tick();
        bus.req_empty = 4'hF;
        check("sat_reuse_tag", 64'(bus.mem_req_tag),  64'd3);
        check("sat_reuse_addr", 64'(bus.mem_req_addr), 64'h20);
        check("sat_outst8",    64'(bus.outstanding),  64'd8);

        // Memory-side and response-side backpressure
        do_reset();
        set_head(2, 16'h0202, 1'b1, 31'h55, 32'h99);
        bus.req_empty = 4'b1011;
        settle();
        check("bp_pop0", 64'(bus.req_rd_en), 64'b0100);
        tick();
        set_head(2, 16'h0203, 1'b0, 31'h56, 32'h9A);
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("bp_nopop%0d", i), 64'(bus.req_rd_en),    64'd0);
            check($sformatf("bp_addr%0d", i),  64'(bus.mem_req_addr), 64'h55);
            check($sformatf("bp_data%0d", i),  64'(bus.mem_req_data), 64'h99);
            tick();
        end
        check("bp_hold_vld", 64'(bus.mem_req_valid), 64'd1);
        check("bp_hold_tag", 64'(bus.mem_req_tag),   64'd0);
        bus.mem_req_ready = 1'b1;
        settle();
        check("bp_pop1", 64'(bus.req_rd_en), 64'b0100);
        tick();
        bus.req_empty = 4'hF;
        check("bp_addr2", 64'(bus.mem_req_addr), 64'h56);
        check("bp_tag2",  64'(bus.mem_req_tag),  64'd1);
        check("bp_rw2",   64'(bus.mem_req_rw),   64'd0);
        tick();
        bus.rsp_full = 4'b0100;
        respond(3'd0, 32'hC0);
        settle();
        check("bp_full_rdy0", 64'(bus.mem_rsp_ready), 64'd0);
        check("bp_full_wr0",  64'(bus.rsp_wr_en),     64'd0);
        tick();
        tick();
        check("bp_full_rdy1", 64'(bus.mem_rsp_ready), 64'd0);
        check("bp_full_wr1",  64'(bus.rsp_wr_en),     64'd0);
        bus.rsp_full = 4'b0000;
        settle();
        check("bp_rdy",     64'(bus.mem_rsp_ready), 64'd1);
        check("bp_wr_en",   64'(bus.rsp_wr_en),     64'b0100);
        check("bp_rsp_dat", 64'(bus.rsp_data),      64'h0202_0000_00C0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        check("bp_outst", 64'(bus.outstanding), 64'd1);

        // Out-of-order responses
        do_reset();
        bus.mem_req_ready = 1'b1;
        set_head(1, 16'h1111, 1'b1, 31'h1, 32'h0);
        set_head(3, 16'h3333, 1'b0, 31'h3, 32'h3);
        bus.req_empty = 4'b0101;
        settle();
        check("ooo_pop0", 64'(bus.req_rd_en), 64'b0010);
        tick();
        bus.req_empty = 4'b0111;
        check("ooo_tag0", 64'(bus.mem_req_tag), 64'd0);
        settle();
        check("ooo_pop1", 64'(bus.req_rd_en), 64'b1000);
        tick();
        bus.req_empty = 4'hF;
        check("ooo_tag1",  64'(bus.mem_req_tag),  64'd1);
        check("ooo_addr1", 64'(bus.mem_req_addr), 64'h3);
        tick();
        respond(3'd1, 32'hD1);
        settle();
        check("ooo_wr1",  64'(bus.rsp_wr_en), 64'b1000);
        check("ooo_dat1", 64'(bus.rsp_data),  64'h3333_0000_00D1);
        tick();
        respond(3'd0, 32'hD0);
        settle();
        check("ooo_wr0",  64'(bus.rsp_wr_en), 64'b0010);
        check("ooo_dat0", 64'(bus.rsp_data),  64'h1111_0000_00D0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        check("ooo_outst", 64'(bus.outstanding), 64'd0);

        // Unallocated tag, then mid-operation reset
        respond(3'd5, 32'hEE);
        settle();
        check("err_rdy",  64'(bus.mem_rsp_ready), 64'd1);
        check("err_wr",   64'(bus.rsp_wr_en),     64'd0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        check("err_set", 64'(bus.err_tag), 64'd1);
        tick();
        check("err_sticky", 64'(bus.err_tag), 64'd1);
        set_head(0, 16'h0A0A, 1'b1, 31'h40, 32'h0);
        bus.req_empty = 4'hE;
        tick();
        tick();
        tick();
        bus.req_empty = 4'hF;
        check("mid_outst3", 64'(bus.outstanding), 64'd3);
        bus.req_empty = 4'hE;
        respond(3'd0, 32'h5);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_req_vld", 64'(bus.mem_req_valid), 64'd0);
        check("mid_outst",   64'(bus.outstanding),   64'd0);
        check("mid_err",     64'(bus.err_tag),       64'd0);
        check("mid_rd_en",   64'(bus.req_rd_en),     64'd0);
        check("mid_wr_en",   64'(bus.rsp_wr_en),     64'd0);
        check("mid_rsp_rdy", 64'(bus.mem_rsp_ready), 64'd0);
        do_reset();
        settle();
        check("post_outst", 64'(bus.outstanding),   64'd0);
        check("post_err",   64'(bus.err_tag),       64'd0);
        check("post_vld",   64'(bus.mem_req_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
